// File: rtl/c432_resp_capture_if.sv
// Response/event bundle between the c432 wrapper stage, the capture block and
// the event consumer.
interface c432_resp_capture_if;
  logic        in_valid;
  logic        pa_in;
  logic        pb_in;
  logic        pc_in;
  logic [3:0]  chan_in;
  logic        ev_valid;
  logic        ev_ready;
  logic [22:0] ev_data;

  // Producer/consumer side (drives samples and ev_ready).
  modport master (
    output in_valid, pa_in, pb_in, pc_in, chan_in, ev_ready,
    input  ev_valid, ev_data
  );

  // Capture block side.
  modport slave (
    input  in_valid, pa_in, pb_in, pc_in, chan_in, ev_ready,
    output ev_valid, ev_data
  );
endinterface

// File: rtl/c432_resp_capture.sv
// Response capture for the c432 wrapper stage: compacts accepted responses into a
// 16-bit MISR, counts samples, and queues time-stamped change events in a FIFO.
module c432_resp_capture #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  c432_resp_capture_if.slave     resp_if,
  output logic [15:0]            signature,
  output logic [15:0]            sample_cnt,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  // State
  logic [15:0]     sig_q, sig_d;
  logic [15:0]     sample_cnt_q, sample_cnt_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     stamp_q, stamp_d;
  logic [6:0]      prev_resp_q, prev_resp_d;
  logic            prev_valid_q, prev_valid_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [22:0]     mem_q [FIFO_DEPTH];

  // Per-edge decisions
  logic [6:0]  resp;
  logic        accept;
  logic        push_req;
  logic        pop;
  logic        full;
  logic        empty;
  logic        do_push;
  logic        drop;
  logic        fb;
  logic [22:0] ev_word;

  // Decode this edge's accept/push/pop/drop decisions.
  always_comb begin
    resp     = {resp_if.pa_in, resp_if.pb_in, resp_if.pc_in, resp_if.chan_in};
    empty    = (count_q == '0);
    full     = (count_q == DepthC);
    // clear wins over both sampling and popping on the same edge
    accept   = resp_if.in_valid & ~clear;
    push_req = accept & (~prev_valid_q | (resp != prev_resp_q));
    pop      = ~empty & resp_if.ev_ready & ~clear;
    // a pop on the same edge frees the slot a full FIFO needs
    do_push  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    fb       = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];
    ev_word  = {stamp_q, resp};
  end

  // Next-state for counters, MISR, history and FIFO pointers.
  always_comb begin
    sig_d        = sig_q;
    sample_cnt_d = sample_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    stamp_d      = stamp_q + 16'd1;
    prev_resp_d  = prev_resp_q;
    prev_valid_d = prev_valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (clear) begin
      sig_d        = 16'hFFFF;
      sample_cnt_d = '0;
      drop_cnt_d   = '0;
      overflow_d   = 1'b0;
      // the clear edge itself carries stamp 0, so the next edge sees 1
      stamp_d      = 16'd1;
      prev_valid_d = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (accept) begin
        sig_d        = {sig_q[14:0], fb} ^ {9'b0, resp};
        sample_cnt_d = (sample_cnt_q == 16'hFFFF) ? sample_cnt_q : sample_cnt_q + 16'd1;
        prev_resp_d  = resp;
        prev_valid_d = 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
        drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
      end
      // power-of-two depth: pointers wrap by natural overflow
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; async reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q        <= 16'hFFFF;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      stamp_q      <= '0;
      prev_resp_q  <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sig_q        <= sig_d;
      sample_cnt_q <= sample_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
      stamp_q      <= stamp_d;
      prev_resp_q  <= prev_resp_d;
      prev_valid_q <= prev_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Event storage; written only on a real (non-dropped) push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= ev_word;
    end
  end

  // Outputs come straight from registers: no input-to-output path.
  always_comb begin
    resp_if.ev_valid = (count_q != '0);
    resp_if.ev_data  = mem_q[rd_ptr_q];
    signature        = sig_q;
    sample_cnt       = sample_cnt_q;
    overflow         = overflow_q;
    drop_cnt         = drop_cnt_q;
  end

endmodule

// File: tb/tb_c432_resp_capture.sv
// Randomised and directed bench for c432_resp_capture against a queue-based model.
module tb_c432_resp_capture;

  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] signature;
  logic [15:0] sample_cnt;
  logic        overflow;
  logic [7:0]  drop_cnt;

  c432_resp_capture_if bus ();

  c432_resp_capture #(.FIFO_DEPTH(Depth)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .resp_if    (bus),
    .signature  (signature),
    .sample_cnt (sample_cnt),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [22:0] m_q[$];
  logic [15:0] m_sig;
  int          m_cnt;
  int          m_drop;
  logic        m_ovf;
  int          m_since;     // edges since reset release / clear edge
  logic [6:0]  m_prev;
  logic        m_prev_v;

  logic        cur_v;
  logic [6:0]  cur_r;
  logic        cur_rdy;
  logic        cur_clr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_sig = 16'hFFFF;
    m_cnt = 0;
    m_drop = 0;
    m_ovf = 1'b0;
    m_since = 0;
    m_prev = '0;
    m_prev_v = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [6:0] r, input logic rdy, input logic clr);
    cur_v = v; cur_r = r; cur_rdy = rdy; cur_clr = clr;
    bus.in_valid = v;
    {bus.pa_in, bus.pb_in, bus.pc_in, bus.chan_in} = r;
    bus.ev_ready = rdy;
    clear = clr;
  endtask

  // Apply the rules for one rising edge to the model, then let the DUT take the edge.
  task automatic step();
    logic pop;
    logic push;
    logic fb;
    int   sz;
    if (cur_clr) begin
      m_q.delete();
      m_sig = 16'hFFFF;
      m_cnt = 0;
      m_drop = 0;
      m_ovf = 1'b0;
      m_prev_v = 1'b0;
      m_since = 1;
    end else begin
      sz = m_q.size();
      pop = (sz != 0) && cur_rdy;
      push = 1'b0;
      if (cur_v) begin
        push = !m_prev_v || (cur_r != m_prev);
        fb = m_sig[15] ^ m_sig[14] ^ m_sig[12] ^ m_sig[3];
        m_sig = {m_sig[14:0], fb} ^ {9'b0, cur_r};
        if (m_cnt < 65535) m_cnt++;
        m_prev = cur_r;
        m_prev_v = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (sz == Depth && !pop) begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end else begin
          m_q.push_back({16'(m_since), cur_r});
        end
      end
      m_since++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    chk({tag, ".ev_valid"}, 32'(bus.ev_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk({tag, ".ev_data"}, 32'(bus.ev_data), 32'(m_q[0]));
    chk({tag, ".signature"}, 32'(signature), 32'(m_sig));
    chk({tag, ".sample_cnt"}, 32'(sample_cnt), 32'(m_cnt));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_low");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] r;
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    m_reset();

    // Reset then idle 3 cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle");
    end
    chk("idle.sig_const", 32'(signature), 32'h0000_FFFF);

    // First two accepted samples after reset
    do_reset();
    drive(1'b1, 7'h00, 1'b1, 1'b0);
    step();
    check("first");
    chk("first.sig_const", 32'(signature), 32'h0000_FFFE);
    chk("first.ev_const", 32'(bus.ev_data), 32'({16'h0000, 7'h00}));
    drive(1'b1, 7'h01, 1'b1, 1'b0);
    step();
    check("second");
    chk("second.sig_const", 32'(signature), 32'h0000_FFFD);
    chk("second.cnt_const", 32'(sample_cnt), 32'd2);
    chk("second.ev_const", 32'(bus.ev_data), 32'({16'h0001, 7'h01}));

    // Repeated resp: one event only
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 7'h55, 1'b0, 1'b0);
      step();
      check("rep55");
    end
    chk("rep55.cnt_const", 32'(sample_cnt), 32'd5);
    drive(1'b0, 7'h55, 1'b1, 1'b0);
    step();
    check("rep55.drain");
    chk("rep55.one_event", 32'(bus.ev_valid), 32'd0);

    // Overflow with consumer stalled
    drive(1'b0, 7'h00, 1'b0, 1'b1);
    step();
    check("ovf.clear");
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 2 == 0) ? 7'h00 : 7'h7F, 1'b0, 1'b0);
      step();
      check("ovf.fill");
    end
    chk("ovf.drop_const", 32'(drop_cnt), 32'd2);
    chk("ovf.flag_const", 32'(overflow), 32'd1);
    chk("ovf.head_const", 32'(bus.ev_data), 32'({16'h0001, 7'h00}));
    drive(1'b0, 7'h7F, 1'b0, 1'b0);
    step();
    check("ovf.hold");

    // Full FIFO, push and pop on the same edge
    drive(1'b1, 7'h00, 1'b1, 1'b0);
    step();
    check("fullpp");
    chk("fullpp.drop_const", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 7'h00, 1'b1, 1'b0);
      step();
      check("drain");
    end

    // Clear beats an accompanying sample
    drive(1'b1, 7'h12, 1'b1, 1'b1);
    step();
    check("clr");
    chk("clr.sig_const", 32'(signature), 32'h0000_FFFF);
    chk("clr.empty_const", 32'(bus.ev_valid), 32'd0);
    drive(1'b1, 7'h12, 1'b0, 1'b0);
    step();
    check("clr.next");
    chk("clr.stamp_const", 32'(bus.ev_data), 32'({16'h0001, 7'h12}));

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = 7'($urandom_range(0, 3)) * 7'h25;
      drive(($urandom % 4) != 0, r, ($urandom % 3) == 0, ($urandom % 60) == 0);
      step();
      check("rand");
    end

    // Asynchronous reset with events queued
    drive(1'b0, 7'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(i + 1), 1'b0, 1'b0);
      step();
      check("arst.fill");
    end
    drive(1'b0, 7'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("arst.low");
    chk("arst.valid_const", 32'(bus.ev_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 7'h3C, 1'b0, 1'b0);
    step();
    check("arst.resume");
    chk("arst.stamp_const", 32'(bus.ev_data), 32'({16'h0000, 7'h3C}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard bound on runtime in case something wedges.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/c432_resp_capture.md
C432_RESP_CAPTURE -- requirements
Module: c432_resp_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO depth; SHALL be a power of two, 2..64.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; SHALL clear all state while low.
REQ-004 clear  input  1  synchronous flush of all capture state.
REQ-005 in_valid  input  1  the response inputs hold a valid sample this cycle.
REQ-006 pa_in, pb_in, pc_in  input  1 each  PA/PB/PC outputs of the c432 wrapper stage.
REQ-007 chan_in  input  4  Chan output of the c432 wrapper stage.
REQ-008 ev_valid  output  1  FIFO head holds an event.
REQ-009 ev_ready  input  1  consumer accepts the head event.
REQ-010 ev_data  output  23  {stamp[15:0], pa, pb, pc, chan[3:0]}; pa at bit 6.
REQ-011 signature  output  16  MISR signature.
REQ-012 sample_cnt  output  16  accepted-sample count, saturating at 16'hFFFF.
REQ-013 overflow  output  1  sticky event-drop flag.
REQ-014 drop_cnt  output  8  dropped-event count, saturating at 8'hFF.

Function
REQ-015 resp SHALL be {pa_in, pb_in, pc_in, chan_in} (7 bits); a sample SHALL be accepted on an edge where in_valid=1 and clear=0.
REQ-016 The 16-bit stamp counter SHALL be 0 on the first edge after reset release, SHALL increment every cycle, and SHALL wrap FFFF->0000.
REQ-017 An event's stamp SHALL be the counter value on the edge its sample is accepted.
REQ-018 MISR per accepted sample: fb = sig[15]^sig[14]^sig[12]^sig[3]; sig_next = {sig[14:0], fb} XOR {9'b0, resp}.
REQ-019 The MISR SHALL hold its value on edges with no accepted sample.
REQ-020 An event SHALL be pushed when an accepted resp differs from the previously accepted resp, or when it is the first accepted sample since reset or clear.
REQ-021 An accepted resp equal to the previous resp SHALL push no event.
REQ-022 Event latency: ev_valid SHALL rise the cycle after the push edge when the FIFO was empty; there is no combinational in-to-out path.
REQ-023 Handshake: the head SHALL pop on an edge with ev_valid=1 and ev_ready=1.
REQ-024 ev_data SHALL be stable while ev_valid=1 and ev_ready=0.
REQ-025 Events SHALL be delivered in order.
REQ-026 Push while full without a pop: the event SHALL be dropped, overflow SHALL set, drop_cnt SHALL increment, and FIFO contents SHALL be unchanged.
REQ-027 Push and pop on the same edge while full: both SHALL occur, with no drop and occupancy unchanged.
REQ-028 Push and pop on the same edge while empty: the event SHALL be stored; ev_valid SHALL be 1 the next cycle.
REQ-029 Pop while empty SHALL be ignored.
REQ-030 Write and read pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 A full/empty distinction SHALL be maintained via an occupancy count or an extra pointer bit.
REQ-032 clear=1 SHALL empty the FIFO, set signature to 16'hFFFF, and zero sample_cnt, drop_cnt, overflow and the stamp counter.
REQ-033 clear=1 SHALL forget the previous resp.
REQ-034 clear SHALL take priority over in_valid and ev_ready on the same edge; no sample is accepted and no pop occurs.

Reset
REQ-035 While rst_n=0: ev_valid=0, signature=16'hFFFF, sample_cnt=0, drop_cnt=0, overflow=0, stamp=0, FIFO empty, previous resp invalid.
REQ-036 Asserting rst_n mid-operation SHALL discard all in-flight events immediately, without waiting for clk.
REQ-037 Operation SHALL resume on the first rising edge with rst_n=1.

Verification
REQ-038 Reset then idle 3 cycles -> ev_valid=0, signature=FFFF, sample_cnt=0, overflow=0.
REQ-039 First two edges after reset accept resp 7'h00 then 7'h01, ev_ready=1 -> signature FFFE then FFFD, sample_cnt=2, events {0000,00} then {0001,01}.
REQ-040 Resp 7'h55 accepted 5 times consecutively -> exactly 1 event, sample_cnt=5.
REQ-041 ev_ready=0, 10 alternating resps 7'h00/7'h7F -> 8 stored events, overflow=1, drop_cnt=2, ev_data holds the oldest event until ev_ready rises.
REQ-042 FIFO full, new resp with ev_ready=1 on the same edge -> occupancy stays 8, drop_cnt unchanged, order preserved.
REQ-043 clear=1 with in_valid=1 -> sample discarded, signature=FFFF, FIFO empty; the next accepted sample pushes an event with stamp 0001.
REQ-044 rst_n pulsed low between clock edges with 4 events queued -> ev_valid falls immediately, and all state equals REQ-035 values.
